vga_scan_controller: RTL and testbench

//  Parametrised VGA raster controller; successor to the fixed 640x480 VgaController.

---
 rtl/vga_scan_controller.sv | 200 ++++++++++++++++++++
 tb/tb_vga_scan_controller.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_controller.sv
// Parametrised VGA raster controller: programmable timing, framebuffer read requests, latency-aligned output.
// Optional build macro VGA_TEST_PATTERN_EN adds I_PATTERN_SEL and an 8-bar colour test pattern.
module vga_scan_controller #(
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int H_ACT      = 640,
  parameter int H_FP       = 16,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int V_ACT      = 480,
  parameter int V_FP       = 10,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int COLOR_W    = 4,
  parameter int ADDR_W     = 19,
  parameter int CNT_W      = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic               I_CLK,
  input  logic               I_RST,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               I_PATTERN_SEL,
`endif
  input  logic [COLOR_W-1:0] I_RED,
  input  logic [COLOR_W-1:0] I_GREEN,
  input  logic [COLOR_W-1:0] I_BLUE,
  output logic               O_REQ,
  output logic [ADDR_W-1:0]  O_ADDRESS,
  output logic [CNT_W-1:0]   O_COORD_X,
  output logic [CNT_W-1:0]   O_COORD_Y,
  output logic               O_FRAME_START,
  output logic               O_LINE_START,
  output logic [COLOR_W-1:0] O_VGA_R,
  output logic [COLOR_W-1:0] O_VGA_G,
  output logic [COLOR_W-1:0] O_VGA_B,
  output logic               O_VGA_H_SYNC,
  output logic               O_VGA_V_SYNC,
  output logic               O_VGA_BLANK,
  output logic               O_VGA_SYNC,
  output logic               O_VGA_CLOCK
);

  localparam int STAGES = RD_LATENCY + 2;
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_SYNC + H_BP + H_ACT + H_FP - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_SYNC + V_BP + V_ACT + V_FP - 1);
  localparam logic [CNT_W-1:0] H_SYN_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYN_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_BEG = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_SYNC + H_BP + H_ACT);
  localparam logic [CNT_W-1:0] V_ACT_BEG = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_SYNC + V_BP + V_ACT);

  // Stage 0: beam counters
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  logic             act0, hs0, vs0, first0;
  logic [CNT_W-1:0] x0, y0;

  always_comb begin
    act0   = (h_q >= H_ACT_BEG) && (h_q < H_ACT_END) && (v_q >= V_ACT_BEG) && (v_q < V_ACT_END);
    x0     = h_q - H_ACT_BEG;
    y0     = v_q - V_ACT_BEG;
    first0 = act0 && (x0 == '0) && (y0 == '0);
    hs0    = (h_q < H_SYN_END) ? H_SYNC_POL : ~H_SYNC_POL;
    vs0    = (v_q < V_SYN_END) ? V_SYNC_POL : ~V_SYNC_POL;
  end

  // Stage 1: request, address and coordinates; all hold while no pixel is requested
  logic              req_q, fs_q, ls_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  x_q, x_d, y_q, y_d;

  always_comb begin
    addr_d = addr_q;
    x_d    = x_q;
    y_d    = y_q;
    if (act0) begin
      x_d    = x0;
      y_d    = y0;
      addr_d = first0 ? '0 : addr_q + 1'b1;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      req_q  <= 1'b0;
      fs_q   <= 1'b0;
      ls_q   <= 1'b0;
      addr_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      req_q  <= act0;
      fs_q   <= first0;
      ls_q   <= act0 && (x0 == '0);
      addr_q <= addr_d;
      x_q    <= x_d;
      y_q    <= y_d;
    end
  end

  // Sync/blank delay line; element k holds the stage-0 value from k cycles ago
  logic [STAGES:1] hs_pipe_q, vs_pipe_q, vld_pipe_q;

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      hs_pipe_q  <= {STAGES{~H_SYNC_POL}};
      vs_pipe_q  <= {STAGES{~V_SYNC_POL}};
      vld_pipe_q <= '0;
    end else begin
      for (int i = STAGES; i > 1; i--) begin
        hs_pipe_q[i]  <= hs_pipe_q[i-1];
        vs_pipe_q[i]  <= vs_pipe_q[i-1];
        vld_pipe_q[i] <= vld_pipe_q[i-1];
      end
      hs_pipe_q[1]  <= hs0;
      vs_pipe_q[1]  <= vs0;
      vld_pipe_q[1] <= act0;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic       pat_q;
  logic [2:0] bar1;
  logic [RD_LATENCY:1][2:0] bar_pipe_q;

  always_comb begin
    bar1 = 3'd0;
    for (int k = 1; k < 8; k++)
      if (x_q >= CNT_W'(k * (H_ACT / 8))) bar1 = bar1 + 3'd1;
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      pat_q      <= 1'b0;
      bar_pipe_q <= '0;
    end else begin
      if (first0) pat_q <= I_PATTERN_SEL;
      for (int i = RD_LATENCY; i > 1; i--) bar_pipe_q[i] <= bar_pipe_q[i-1];
      bar_pipe_q[1] <= bar1;
    end
  end
`endif

  // Output stage: host data lines up with the blank bit one stage before the output
  logic [COLOR_W-1:0] r_q, g_q, b_q;

  always_ff @(posedge I_CLK) begin
    if (I_RST || !vld_pipe_q[STAGES-1]) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
`ifdef VGA_TEST_PATTERN_EN
    end else if (pat_q) begin
      r_q <= {COLOR_W{~bar_pipe_q[RD_LATENCY][1]}};
      g_q <= {COLOR_W{~bar_pipe_q[RD_LATENCY][2]}};
      b_q <= {COLOR_W{~bar_pipe_q[RD_LATENCY][0]}};
`endif
    end else begin
      r_q <= I_RED;
      g_q <= I_GREEN;
      b_q <= I_BLUE;
    end
  end

  assign O_REQ         = req_q;
  assign O_ADDRESS     = addr_q;
  assign O_COORD_X     = x_q;
  assign O_COORD_Y     = y_q;
  assign O_FRAME_START = fs_q;
  assign O_LINE_START  = ls_q;
  assign O_VGA_R       = r_q;
  assign O_VGA_G       = g_q;
  assign O_VGA_B       = b_q;
  assign O_VGA_H_SYNC  = hs_pipe_q[STAGES];
  assign O_VGA_V_SYNC  = vs_pipe_q[STAGES];
  assign O_VGA_BLANK   = vld_pipe_q[STAGES];
  assign O_VGA_SYNC    = 1'b0;
  assign O_VGA_CLOCK   = I_CLK;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller: small raster, RD_LATENCY=3, random host data, arithmetic beam model.
module tb_vga_scan_controller;
  localparam int HS = 8, HB = 6, HA = 32, HF = 4;
  localparam int VS = 2, VB = 3, VA = 6, VF = 2;
  localparam int CW = 4, AW = 8, NW = 6, L = 3;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FR = HT * VT;
  localparam int ST = L + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CW-1:0] ir = '0, ig = '0, ib = '0;
`ifdef VGA_TEST_PATTERN_EN
  logic psel = 1'b0;
`endif
  logic          o_req, o_fs, o_ls, o_r_hs, o_vs, o_bl, o_sync, o_clk;
  logic [AW-1:0] o_addr;
  logic [NW-1:0] o_x, o_y;
  logic [CW-1:0] o_r, o_g, o_b;

  always #5 clk = ~clk;

  vga_scan_controller #(
    .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0),
    .COLOR_W(CW), .ADDR_W(AW), .CNT_W(NW), .RD_LATENCY(L)
  ) dut (
    .I_CLK(clk), .I_RST(rst),
`ifdef VGA_TEST_PATTERN_EN
    .I_PATTERN_SEL(psel),
`endif
    .I_RED(ir), .I_GREEN(ig), .I_BLUE(ib),
    .O_REQ(o_req), .O_ADDRESS(o_addr), .O_COORD_X(o_x), .O_COORD_Y(o_y),
    .O_FRAME_START(o_fs), .O_LINE_START(o_ls),
    .O_VGA_R(o_r), .O_VGA_G(o_g), .O_VGA_B(o_b),
    .O_VGA_H_SYNC(o_r_hs), .O_VGA_V_SYNC(o_vs), .O_VGA_BLANK(o_bl),
    .O_VGA_SYNC(o_sync), .O_VGA_CLOCK(o_clk)
  );

  // Host memory: red mirrors address[3:0], green/blue random per address
  logic [CW-1:0] tg [256];
  logic [CW-1:0] tbb[256];
  logic [AW-1:0] ahist[L+1];
  logic          rhist[L+1];

  always @(posedge clk) begin
    #1;
    for (int i = L; i > 0; i--) begin
      ahist[i] = ahist[i-1];
      rhist[i] = rhist[i-1];
    end
    ahist[0] = o_addr;
    rhist[0] = o_req;
    if (rhist[L]) begin
      ir = ahist[L][3:0];
      ig = tg[ahist[L]];
      ib = tbb[ahist[L]];
    end else begin
      {ir, ig, ib} = 12'($urandom);
    end
  end

  int errors = 0, checks = 0;
  int t;
  int nreq, nfs;
  bit seg_sel = 1'b0;
  logic [NW-1:0] mx, my;
  logic [AW-1:0] maddr;
  logic [11:0] bars[8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};

  function automatic bit act(int p);
    int h, v;
    if (p < 0) return 1'b0;
    h = p % HT;
    v = (p / HT) % VT;
    return (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, t);
    end
  endtask

  task automatic step_check();
    int p, h, v, x, y, a;
    logic ereq, efs, els;
    logic [11:0] ergb;
    p = t - 1;
    ereq = act(p);
    efs = 1'b0;
    els = 1'b0;
    if (ereq) begin
      x = p % HT - HS - HB;
      y = (p / HT) % VT - VS - VB;
      mx = NW'(x);
      my = NW'(y);
      maddr = AW'(y * HA + x);
      efs = (x == 0) && (y == 0);
      els = (x == 0);
    end
    chk("req", o_req, ereq);
    chk("addr", o_addr, maddr);
    chk("x", o_x, mx);
    chk("y", o_y, my);
    chk("frame_start", o_fs, efs);
    chk("line_start", o_ls, els);
    p = t - ST;
    h = (p < 0) ? 0 : p % HT;
    v = (p < 0) ? 0 : (p / HT) % VT;
    ergb = 12'h000;
    if (act(p)) begin
      x = h - HS - HB;
      y = v - VS - VB;
      a = y * HA + x;
      ergb = seg_sel ? bars[x / (HA / 8)] : {4'(a), tg[a], tbb[a]};
    end
    chk("hsync", o_r_hs, (p < 0) ? 1'b1 : (h >= HS));
    chk("vsync", o_vs, (p < 0) ? 1'b1 : (v >= VS));
    chk("blank", o_bl, act(p));
    chk("rgb", {o_r, o_g, o_b}, ergb);
    chk("vga_sync", o_sync, 1'b0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step_check();
      nreq += int'(o_req);
      nfs  += int'(o_fs);
      @(negedge clk);
      t++;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    mx = '0;
    my = '0;
    maddr = '0;
    t = -100;
    step_check();
    rst = 1'b0;
    t = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      tg[i]  = 4'($urandom);
      tbb[i] = 4'($urandom);
    end
    for (int i = 0; i <= L; i++) begin
      ahist[i] = '0;
      rhist[i] = 1'b0;
    end
    @(negedge clk);
    do_reset(5);
    nreq = 0;
    nfs = 0;
    run(2 * FR);
    chk("req_count_2frames", nreq, 2 * HA * VA);
    chk("frame_start_count", nfs, 2);
    run($urandom_range(1, FR - 1));
    do_reset(1);
    run(FR + 50);
    run($urandom_range(1, FR - 1));
    do_reset($urandom_range(1, 3));
    run(FR);
`ifdef VGA_TEST_PATTERN_EN
    psel = 1'b1;
    seg_sel = 1'b1;
    do_reset(2);
    run(FR + 50);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
